// File: rtl/qeciphy_pchan_pkg.sv
// Shared types and constants for the QECIPHY P-channel initiator.
package qeciphy_pchan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } pchan_state_t;

  localparam logic PSTATE_RUN  = 1'b1;
  localparam logic PSTATE_STOP = 1'b0;

endpackage

// File: rtl/qeciphy_pchan_timeout.sv
// Saturating ASSERT-phase cycle counter with a sticky timeout flag.
// Instantiated by qeciphy_pchan_initiator only when QECIPHY_PCHAN_TIMEOUT_EN is defined.
module qeciphy_pchan_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARSTn,
  input  logic in_assert,
  input  logic paccept,
  input  logic clr_err,
  output logic timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_d;
  logic             hit_c;

  // Count only while ASSERT is held; the flag is set on the edge that completes
  // the TIMEOUT_CYCLES-th unanswered cycle, and a set beats a same-cycle clear.
  always_comb begin
    cnt_d = '0;
    if (in_assert) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    hit_c = in_assert && !paccept && (cnt_q == CNT_HIT);
    err_d = timeout_err;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (hit_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timeout_err <= err_d;
    end
  end

endmodule

// File: rtl/qeciphy_pchan_initiator.sv
// 4-phase P-channel initiator driving QECIPHY PSTATE/PREQ from a valid/ready command port.
// Optional timeout detection is built when QECIPHY_PCHAN_TIMEOUT_EN is defined.
module qeciphy_pchan_initiator
  import qeciphy_pchan_pkg::*;
#(
  parameter logic        RESET_PSTATE   = PSTATE_RUN,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARSTn,
  input  logic req_valid,
  input  logic req_state,
  output logic req_ready,
  input  logic auto_wake_en,
  input  logic clr_err,
  output logic PSTATE,
  output logic PREQ,
  input  logic PACCEPT,
  input  logic PACTIVE,
  output logic cur_state,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  pchan_state_t state_q;
  pchan_state_t state_d;
  logic         target_q;
  logic         target_d;
  logic         cur_d;
  logic         preq_d;
  logic         pstate_d;
  logic         done_d;

  // Next-state and next-output decode; PREQ/PSTATE are derived from the next state
  // so they appear on the same edge that moves the FSM.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_state;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = ASSERT;
          target_d = req_state;
        end else if (auto_wake_en && PACTIVE && (cur_state == PSTATE_STOP)) begin
          state_d  = ASSERT;
          target_d = PSTATE_RUN;
        end
      end
      ASSERT: begin
        if (PACCEPT) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!PACCEPT) begin
          state_d = IDLE;
          cur_d   = target_q;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    preq_d   = (state_d == ASSERT);
    pstate_d = (state_d == IDLE) ? cur_d : target_d;
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q   <= IDLE;
      target_q  <= RESET_PSTATE;
      cur_state <= RESET_PSTATE;
      PREQ      <= 1'b0;
      PSTATE    <= RESET_PSTATE;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_state <= cur_d;
      PREQ      <= preq_d;
      PSTATE    <= pstate_d;
      done      <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

`ifdef QECIPHY_PCHAN_TIMEOUT_EN
  qeciphy_pchan_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .ACLK       (ACLK),
    .ARSTn      (ARSTn),
    .in_assert  (state_q == ASSERT),
    .paccept    (PACCEPT),
    .clr_err    (clr_err),
    .timeout_err(timeout_err)
  );
`else
  // Without timeout support the flag is constant and the related inputs are dead.
  logic unused_cfg;
  assign unused_cfg  = ^{clr_err, 32'(TIMEOUT_CYCLES)};
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_qeciphy_pchan_initiator.sv
// Self-checking bench for qeciphy_pchan_initiator; timeout checks follow QECIPHY_PCHAN_TIMEOUT_EN.
module tb_qeciphy_pchan_initiator;

  localparam int unsigned TB_TO = 8;

  logic ACLK = 1'b0;
  logic ARSTn = 1'b0;
  logic req_valid = 1'b0;
  logic req_state = 1'b0;
  logic req_ready;
  logic auto_wake_en = 1'b0;
  logic clr_err = 1'b0;
  logic PSTATE;
  logic PREQ;
  logic PACCEPT;
  logic PACTIVE = 1'b0;
  logic cur_state;
  logic busy;
  logic done;
  logic timeout_err;

  logic paccept_drv = 1'b0;
  logic phy_comb = 1'b0;
  logic model_cur = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // PHY stand-in: either scripted by the tasks or a zero-delay echo of PREQ.
  assign PACCEPT = phy_comb ? PREQ : paccept_drv;

  always #5 ACLK = ~ACLK;

  qeciphy_pchan_initiator #(
    .RESET_PSTATE  (1'b1),
    .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .ACLK        (ACLK),
    .ARSTn       (ARSTn),
    .req_valid   (req_valid),
    .req_state   (req_state),
    .req_ready   (req_ready),
    .auto_wake_en(auto_wake_en),
    .clr_err     (clr_err),
    .PSTATE      (PSTATE),
    .PREQ        (PREQ),
    .PACCEPT     (PACCEPT),
    .PACTIVE     (PACTIVE),
    .cur_state   (cur_state),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Presents one command for one edge; returns at the negedge after acceptance.
  task automatic launch(input logic st);
    req_valid = 1'b1;
    req_state = st;
    paccept_drv = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL launch_ready got %b exp 1", req_ready); end
    @(negedge ACLK);
    req_valid = 1'b0;
  endtask

  // PHY raises PACCEPT after acc cycles of PREQ, drops it rel cycles after PREQ falls.
  // Transaction-level expectations: PREQ high acc+1 cycles, busy acc+rel+2 cycles.
  task automatic complete_hs(input logic tgt, input int acc, input int rel, input string tag);
    int preq_n = 0, busy_n = 0, done_n = 0, rdy_n = 0, pst_bad = 0;
    for (int c = 0; c < acc + rel + 2; c++) begin
      paccept_drv = (c >= acc) && (c <= acc + rel);
      if (PREQ === 1'b1) preq_n++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) done_n++;
      if (req_ready === 1'b1) rdy_n++;
      if (PSTATE !== tgt) pst_bad++;
      @(negedge ACLK);
    end
    paccept_drv = 1'b0;
    checks++; if (preq_n != acc + 1) begin errors++; $display("FAIL %s preq_cycles got %0d exp %0d", tag, preq_n, acc + 1); end
    checks++; if (busy_n != acc + rel + 2) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", tag, busy_n, acc + rel + 2); end
    checks++; if (done_n != 0 || rdy_n != 0) begin errors++; $display("FAIL %s early_done_ready got %0d/%0d exp 0/0", tag, done_n, rdy_n); end
    checks++; if (pst_bad != 0) begin errors++; $display("FAIL %s pstate_unstable got %0d exp 0", tag, pst_bad); end
    model_cur = tgt;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse got %b exp 1", tag, done); end
    checks++; if (cur_state !== model_cur) begin errors++; $display("FAIL %s cur_state got %b exp %b", tag, cur_state, model_cur); end
    checks++; if (PSTATE !== model_cur || PREQ !== 1'b0) begin errors++; $display("FAIL %s idle_pins got %b/%b exp %b/0", tag, PSTATE, PREQ, model_cur); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_after got %b exp 1", tag, req_ready); end
    @(negedge ACLK);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b exp 0", tag, done); end
  endtask

  task automatic test_reset;
    ARSTn = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++; if (PREQ !== 1'b0) begin errors++; $display("FAIL rst_preq got %b exp 0", PREQ); end
    checks++; if (PSTATE !== 1'b1) begin errors++; $display("FAIL rst_pstate got %b exp 1", PSTATE); end
    checks++; if (cur_state !== 1'b1) begin errors++; $display("FAIL rst_cur got %b exp 1", cur_state); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b/%b exp 0/0", busy, done); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", timeout_err); end
    ARSTn = 1'b1;
    @(negedge ACLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    model_cur = 1'b1;
  endtask

  task automatic test_stop_request;
    launch(1'b0);
    checks++; if (PREQ !== 1'b1 || PSTATE !== 1'b0) begin errors++; $display("FAIL stop_first got %b/%b exp 1/0", PREQ, PSTATE); end
    complete_hs(1'b0, 3, 2, "stop");
  endtask

  task automatic test_auto_wake;
    // No wake while disabled, then wake from STOP.
    auto_wake_en = 1'b0; PACTIVE = 1'b1;
    repeat (2) @(negedge ACLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wake_disabled got busy %b exp 0", busy); end
    auto_wake_en = 1'b1;
    @(negedge ACLK);
    checks++; if (PREQ !== 1'b1 || PSTATE !== 1'b1) begin errors++; $display("FAIL wake_start got %b/%b exp 1/1", PREQ, PSTATE); end
    complete_hs(1'b1, 1, 1, "wake");
    // Already RUN: PACTIVE must not start another handshake.
    repeat (2) @(negedge ACLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wake_in_run got busy %b exp 0", busy); end
    auto_wake_en = 1'b0;
    launch(1'b0);
    complete_hs(1'b0, 0, 0, "wake_prep");
    // External STOP and wake in the same cycle: external wins.
    auto_wake_en = 1'b1; req_valid = 1'b1; req_state = 1'b0;
    @(negedge ACLK);
    req_valid = 1'b0; auto_wake_en = 1'b0;
    checks++; if (PREQ !== 1'b1 || PSTATE !== 1'b0) begin errors++; $display("FAIL wake_prio got %b/%b exp 1/0", PREQ, PSTATE); end
    complete_hs(1'b0, 2, 1, "wake_prio");
    PACTIVE = 1'b0;
  endtask

  task automatic test_random;
    logic st;
    int acc, rel, gap;
    for (int n = 0; n < 24; n++) begin
      st = 1'($urandom_range(0, 1));
      acc = int'($urandom_range(0, 5));
      rel = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 2));
      auto_wake_en = 1'($urandom_range(0, 1));
      // PACCEPT noise in IDLE must be ignored.
      for (int g = 0; g < gap; g++) begin
        paccept_drv = 1'($urandom_range(0, 1));
        @(negedge ACLK);
        checks++; if (PREQ !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_idle got preq %b busy %b exp 0/0", PREQ, busy); end
      end
      launch(st);
      complete_hs(st, acc, rel, "rnd");
    end
    auto_wake_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc_cyc[$];
    logic exp_q[$];
    logic nxt, e, prev_busy, prev_pst;
    int issued = 0, dones = 0, pst_bad = 0, gap_bad = 0, cur_bad = 0;
    phy_comb = 1'b1;
    nxt = ~model_cur;
    prev_busy = 1'b0;
    prev_pst = PSTATE;
    for (int c = 0; c < 80 && dones < 6; c++) begin
      if (done === 1'b1) begin
        dones++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~cur_state;
        if (cur_state !== e) cur_bad++;
        model_cur = e;
      end
      if (busy === 1'b1 && prev_busy === 1'b1 && PSTATE !== prev_pst) pst_bad++;
      prev_busy = busy;
      prev_pst = PSTATE;
      if (req_ready === 1'b1 && issued < 6) begin
        req_valid = 1'b1; req_state = nxt;
        exp_q.push_back(nxt); acc_cyc.push_back(c);
        issued++; nxt = ~nxt;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge ACLK);
    end
    req_valid = 1'b0;
    phy_comb = 1'b0;
    for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 3) gap_bad++;
    checks++; if (dones != 6 || issued != 6) begin errors++; $display("FAIL b2b_count got %0d/%0d exp 6/6", dones, issued); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps exp 0", gap_bad); end
    checks++; if (cur_bad != 0) begin errors++; $display("FAIL b2b_cur got %0d bad exp 0", cur_bad); end
    checks++; if (pst_bad != 0) begin errors++; $display("FAIL b2b_pstate got %0d changes exp 0", pst_bad); end
    @(negedge ACLK);
  endtask

  task automatic test_timeout;
    logic t;
    t = ~model_cur;
    launch(t);
`ifdef QECIPHY_PCHAN_TIMEOUT_EN
    for (int k = 1; k <= int'(TB_TO) + 3; k++) begin
      @(negedge ACLK);
      checks++; if (timeout_err !== 1'(k >= int'(TB_TO))) begin errors++; $display("FAIL to_flag cyc %0d got %b exp %b", k, timeout_err, 1'(k >= int'(TB_TO))); end
      checks++; if (PREQ !== 1'b1) begin errors++; $display("FAIL to_preq cyc %0d got %b exp 1", k, PREQ); end
    end
    complete_hs(t, 0, 1, "to_done");
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
    clr_err = 1'b1;
    @(negedge ACLK);
    clr_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timeout_err); end
    // clr_err held: set still wins on the hit edge, then clears next cycle.
    t = ~model_cur;
    launch(t);
    clr_err = 1'b1;
    for (int k = 1; k <= int'(TB_TO) + 1; k++) begin
      @(negedge ACLK);
      checks++; if (timeout_err !== 1'(k == int'(TB_TO))) begin errors++; $display("FAIL to_prio cyc %0d got %b exp %b", k, timeout_err, 1'(k == int'(TB_TO))); end
    end
    clr_err = 1'b0;
    complete_hs(t, 1, 0, "to_prio_done");
`else
    for (int k = 1; k <= int'(TB_TO) + 4; k++) begin
      clr_err = k[0];
      @(negedge ACLK);
      checks++; if (timeout_err !== 1'b0 || PREQ !== 1'b1) begin errors++; $display("FAIL noto_flag cyc %0d got err %b preq %b exp 0/1", k, timeout_err, PREQ); end
    end
    clr_err = 1'b0;
    complete_hs(t, 0, 1, "noto_done");
`endif
  endtask

  task automatic test_reset_in_release;
    if (model_cur !== 1'b1) begin
      launch(1'b1);
      complete_hs(1'b1, 0, 0, "rr_prep");
    end
    launch(1'b0);
    paccept_drv = 1'b1;
    @(negedge ACLK);
    checks++; if (busy !== 1'b1 || PREQ !== 1'b0) begin errors++; $display("FAIL rr_release got busy %b preq %b exp 1/0", busy, PREQ); end
    #2 ARSTn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || PREQ !== 1'b0) begin errors++; $display("FAIL rr_async got busy %b done %b preq %b exp 0/0/0", busy, done, PREQ); end
    checks++; if (cur_state !== 1'b1 || PSTATE !== 1'b1) begin errors++; $display("FAIL rr_state got cur %b pstate %b exp 1/1", cur_state, PSTATE); end
    paccept_drv = 1'b0;
    @(negedge ACLK);
    ARSTn = 1'b1;
    model_cur = 1'b1;
    @(negedge ACLK);
    checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rr_after got done %b ready %b exp 0/1", done, req_ready); end
  endtask

  initial begin
    test_reset();
    test_stop_request();
    test_auto_wake();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_in_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
